// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
//   Shared types and constants for the data-memory arbiter (dm_arbiter) and
//   its byte-lane merge helper (dm_be_merge).
//
//   dm_arb_state_t : sequencer states IDLE / RD / WR
//   DM_ARB_NPORTS  : number of requesting masters
//   BE_FULL        : byte-enable pattern for a whole-word store
//   BE_NONE        : byte-enable pattern for a store that touches nothing
// -----------------------------------------------------------------------------
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } dm_arb_state_t;

    localparam int         DM_ARB_NPORTS = 2;
    localparam logic [3:0] BE_FULL       = 4'hF;
    localparam logic [3:0] BE_NONE       = 4'h0;

endpackage

// File: rtl/dm_be_merge.sv
// -----------------------------------------------------------------------------
// dm_be_merge
//   Combinational byte-lane merge used by the read-modify-write path: each
//   byte lane of the result comes from new_i when its enable is set, else
//   from old_i.
//
//   old_i    in  32  word currently held in memory
//   new_i    in  32  lane-aligned store data
//   be_i     in  4   byte enables, bit i selects lane i
//   merged_o out 32  word to write back
// -----------------------------------------------------------------------------
module dm_be_merge (
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    input  logic [3:0]  be_i,
    output logic [31:0] merged_o
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign merged_o[8*g +: 8] = be_i[g] ? new_i[8*g +: 8] : old_i[8*g +: 8];
    end

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//   Two-requester arbiter/sequencer in front of the single-port, word-wide
//   data memory. One request is outstanding at a time. Loads take one read
//   cycle, full-word stores one write cycle, partial stores a read cycle then
//   a write cycle (read-modify-write), and stores with no byte enables finish
//   without touching memory.
//
//   Configuration macro:
//     DM_ARB_RR_EN  defined   : round-robin between the two ports
//                   undefined : fixed priority, port 0 always wins
//
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     reqN_valid/ready      request handshake (N = 0 CPU, 1 secondary)
//     reqN_we/addr/wdata/be/pc  request payload
//     rspN_valid            one-cycle completion pulse
//     rspN_rdata            last load data for port N (held)
//     mem_we/addr/wd/pc     to DM.MemWrite / address / WD / PC
//     mem_rd                from DM.RD (combinational read)
// -----------------------------------------------------------------------------
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [3:0]        req0_be,
    input  logic [31:0]       req0_pc,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [3:0]        req1_be,
    input  logic [31:0]       req1_pc,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    output logic [31:0]       mem_pc,
    input  logic [DATA_W-1:0] mem_rd
);

    dm_arb_state_t state_q, state_d;

    logic gnt_port;     // port index chosen by the arbiter this cycle
    logic hs;           // a handshake happens this cycle

    // Selected request payload
    logic              sel_we;
    logic [ADDR_W-3:0] sel_waddr;
    logic [DATA_W-1:0] sel_wdata;
    logic [3:0]        sel_be;
    logic [31:0]       sel_pc;

    // Latched request
    logic              we_q;
    logic [ADDR_W-3:0] addr_q;
    logic [DATA_W-1:0] wbuf_q;   // store data, then merged word for partial stores
    logic [3:0]        be_q;
    logic [31:0]       pc_q;
    logic              port_q;

    logic [DATA_W-1:0] merged;
    logic [1:0]        rsp_valid_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    // Byte-offset bits are deliberately ignored: memory is word-addressed.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{req0_addr[1:0], req1_addr[1:0]};

    // ------------------------------------------------------------ arbitration
`ifdef DM_ARB_RR_EN
    logic last_q;   // port granted at the most recent handshake

    always_comb begin
        if (req0_valid && req1_valid) begin
            gnt_port = ~last_q;
        end else begin
            gnt_port = req1_valid;
        end
    end

    // Reset to 1 so port 0 wins the first contest.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (hs) begin
            last_q <= gnt_port;
        end
    end
`else
    assign gnt_port = ~req0_valid;
`endif

    assign hs         = !reset && (state_q == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = hs && !gnt_port;
    assign req1_ready = hs &&  gnt_port;

    assign sel_we    = gnt_port ? req1_we                  : req0_we;
    assign sel_waddr = gnt_port ? req1_addr[ADDR_W-1:2]    : req0_addr[ADDR_W-1:2];
    assign sel_wdata = gnt_port ? req1_wdata               : req0_wdata;
    assign sel_be    = gnt_port ? req1_be                  : req0_be;
    assign sel_pc    = gnt_port ? req1_pc                  : req0_pc;

    // ------------------------------------------------------------ next state
    // NOTE: state_d gets a default before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    if (!sel_we) begin
                        state_d = RD;
                    end else if (sel_be == BE_FULL) begin
                        state_d = WR;
                    end else if (sel_be != BE_NONE) begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = we_q ? WR : IDLE;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------ control regs
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rsp_valid_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    // Empty store: acknowledge without a memory access.
                    if (hs && sel_we && (sel_be == BE_NONE)) begin
                        rsp_valid_q[gnt_port] <= 1'b1;
                    end
                end
                RD: begin
                    if (!we_q) begin
                        rsp_valid_q[port_q] <= 1'b1;
                        if (port_q) begin
                            rdata1_q <= mem_rd;
                        end else begin
                            rdata0_q <= mem_rd;
                        end
                    end
                end
                WR:      rsp_valid_q[port_q] <= 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------ payload regs
    // NOTE: payload registers carry no reset; they are only observed in RD/WR,
    // which are reachable solely through a handshake that loads them.
    always_ff @(posedge clk) begin
        if (hs) begin
            we_q   <= sel_we;
            addr_q <= sel_waddr;
            wbuf_q <= sel_wdata;
            be_q   <= sel_be;
            pc_q   <= sel_pc;
            port_q <= gnt_port;
        end else if ((state_q == RD) && we_q) begin
            wbuf_q <= merged;
        end
    end

    dm_be_merge u_merge (
        .old_i    (mem_rd),
        .new_i    (wbuf_q),
        .be_i     (be_q),
        .merged_o (merged)
    );

    // ------------------------------------------------------------ outputs
    logic active;
    assign active = !reset && (state_q != IDLE);

    assign mem_we   = !reset && (state_q == WR);
    assign mem_addr = active ? {addr_q, 2'b00} : '0;
    assign mem_wd   = mem_we ? wbuf_q : '0;
    assign mem_pc   = active ? pc_q : '0;

    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_rdata = rdata0_q;
    assign rsp1_rdata = rdata1_q;

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester arbiter and sequencer in front of the single-port, word-wide data memory (`DM`). It accepts load/store requests from the CPU MEM stage (port 0) and a secondary master such as a debug loader or DMA (port 1). It grants one request at a time and drives the memory's `MemWrite`/`address`/`WD`/`PC` inputs. Byte and halfword stores are implemented as a read-modify-write, because the memory only supports whole-word writes.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, data width; fixed at 32.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `req{0,1}_valid`  in  1  request present.
- `req{0,1}_ready`  out  1  request accepted this cycle.
- `req{0,1}_we`  in  1  1 = store, 0 = load.
- `req{0,1}_addr`  in  32  byte address; bits [1:0] ignored.
- `req{0,1}_wdata`  in  32  store data, already lane-aligned.
- `req{0,1}_be`  in  4  byte enables; bit i selects byte lane i.
- `req{0,1}_pc`  in  32  PC of the issuing instruction; passed to the memory for logging.
- `rsp{0,1}_valid`  out  1  one-cycle completion pulse.
- `rsp{0,1}_rdata`  out  32  load data, valid with `rsp_valid`; holds its value until the next load completes.
- `mem_we`  out  1  to `DM.MemWrite`.
- `mem_addr`  out  32  to `DM.address`; word-aligned.
- `mem_wd`  out  32  to `DM.WD`.
- `mem_pc`  out  32  to `DM.PC`.
- `mem_rd`  in  32  from `DM.RD`; combinational read.

## Operation
The block is a state machine with three states: IDLE, RD, WR.

IDLE:
- Grant is computed combinationally from the `valid` inputs.
- `reqN_ready` is 1 only for the granted port, and only when `reqN_valid` = 1.
- On handshake, latch `we`, the word address, `wdata`, `be`, `pc`, and the port id.
- Next state:
  - load → RD.
  - store with `be` = 4'hF → WR.
  - store with `be` = 4'h0 → no memory access; pulse `rsp_valid`; stay in IDLE.
  - any other store → RD.

RD:
- `mem_addr` = latched address.
- For a load: capture `mem_rd` into that port's `rdata` register, then go to IDLE.
- For a partial store: merge `mem_rd` with `wdata` lane-by-lane under `be` into the write buffer, then go to WR.

WR:
- `mem_we` = 1, `mem_addr`/`mem_wd`/`mem_pc` driven from latches.
- Then go to IDLE.

General rules:
- `rsp_valid` is registered and pulses for exactly one cycle after the last RD or WR cycle.
- Outputs when not in RD or WR:
  - `mem_addr`, `mem_wd`, `mem_pc` = 0.
  - `mem_we` = `(state==WR) && !reset`.
- Only one request is outstanding at a time; no ready is asserted outside IDLE.

Reset values: state = IDLE; all `ready`, `rsp_valid`, `mem_*` outputs = 0; `rsp_rdata` = 0; last-grant pointer = 1, so port 0 wins the first contest.

## Timing
Latency is measured from the handshake cycle T:
- Load: RD at T+1, `rsp_valid` at T+2.
- Full store: write at T+1, `rsp_valid` at T+2.
- Partial store: RD at T+1, WR at T+2, `rsp_valid` at T+3.
- Store with `be` = 0: `rsp_valid` at T+1.

Throughput and back-to-back behaviour:
- The next handshake can occur in the same cycle `rsp_valid` is high, since the FSM is back in IDLE.
- If both ports are valid in the same cycle, one is granted per the arbitration policy. The loser's `ready` stays 0 and it must hold its request stable.

Reset:
- `reset` asserted in any state aborts the access.
- No write reaches memory in the reset cycle.
- No `rsp_valid` is issued for the aborted request.

Address handling: `mem_addr` = `{addr[31:2], 2'b00}`. Address range checking is not performed here.

## Configuration
- `DM_ARB_RR_EN` defined: round-robin. On a simultaneous request, the port not granted last wins. The pointer updates on every handshake.
- `DM_ARB_RR_EN` undefined: fixed priority, port 0 always wins. The pointer register is absent.

## Structure
- Package `dm_arb_pkg` holds:
  - state enum `dm_arb_state_t` {IDLE, RD, WR};
  - `DM_ARB_NPORTS` = 2;
  - `BE_FULL` = 4'hF;
  - `BE_NONE` = 4'h0.
- One sub-module, `dm_be_merge`: purely combinational. Inputs `old[31:0]`, `new[31:0]`, `be[3:0]`; output is the merged word.

## Test plan
- Port 0 full store to `addr` 0x10, data 0xDEADBEEF; then a load from 0x10 → `mem_we` for 1 cycle at T+1; load returns `rsp0_rdata` = 0xDEADBEEF at T+2.
- Memory holds 0x11223344 at 0x20; port 1 stores `be` = 4'b0010, `wdata` = 0x0000AA00 → RD at T+1, WR at T+2 with `mem_wd` = 0x1122AA44, `rsp1_valid` at T+3.
- Both ports valid continuously with loads:
  - with `DM_ARB_RR_EN`, grants alternate 0,1,0,1 starting with 0;
  - without it, port 0 is granted every time and port 1 is starved.
- Store with `be` = 0 → no `mem_we` pulse; `rsp_valid` at T+1.
- Partial store with `reset` asserted during WR → `mem_we` stays 0, memory unchanged, no `rsp_valid`, FSM in IDLE next cycle.
